// File: rtl/rvx_spi_peripheral.sv
// SPI responder (target) peer for the RVX SPI controller.
// Oversamples sclk/cs/pico; host side uses valid/ready handshakes.
//
// Ports:
//   clock, reset       system clock, async active-high reset
//   sclk, pico, cs     SPI pins from the controller (cs active low)
//   poci               peripheral-out data
//   tx_data/valid/ready  host word to send (one-deep holding register)
//   rx_data/valid/ready  last received word, held until accepted
//   overrun            pulse: word dropped because rx_data not accepted
//   underrun           pulse: DEFAULT_TX_WORD loaded, holding empty
module rvx_spi_peripheral #(
    parameter bit                    CPOL            = 1'b0,
    parameter bit                    CPHA            = 1'b0,
    parameter int unsigned           DATA_WIDTH      = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX_WORD = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  pico,
    input  logic                  cs,
    output logic                  poci,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                state_q;
    logic                  sclk_meta_q;
    logic                  sclk_sync_q;
    logic                  sclk_prev_q;
    logic                  cs_meta_q;
    logic                  cs_sync_q;
    logic                  pico_meta_q;
    logic                  pico_sync_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_full_q;
    logic [DATA_WIDTH-1:0] rx_shift_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  overrun_q;
    logic                  underrun_q;

    logic                  sclk_edge;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_edge;
    logic                  shift_edge;
    logic                  last_bit;
    logic                  do_load;
    logic                  hold_wr;
    logic [DATA_WIDTH-1:0] rx_word;

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign sclk_edge   = sclk_sync_q != sclk_prev_q;
    assign lead_edge   = sclk_edge && (sclk_prev_q == CPOL);
    assign trail_edge  = sclk_edge && (sclk_sync_q == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign last_bit = bit_cnt_q == CW'(DATA_WIDTH - 1);
    assign rx_word  = {rx_shift_q[DATA_WIDTH-2:0], pico_sync_q};
    assign hold_wr  = tx_valid && !hold_full_q;

    // CPHA=0 must present the MSB before the first leading edge, so the
    // word is loaded as cs is seen low. Otherwise a load happens on the
    // shift edge that starts each word (bit count at zero).
    always_comb begin
        do_load = 1'b0;
        if (!cs_sync_q) begin
            if (state_q == IDLE) begin
                do_load = !CPHA;
            end else begin
                do_load = shift_edge && (bit_cnt_q == '0);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sclk_meta_q <= CPOL;
            sclk_sync_q <= CPOL;
            sclk_prev_q <= CPOL;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            pico_meta_q <= 1'b0;
            pico_sync_q <= 1'b0;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= cs;
            cs_sync_q   <= cs_meta_q;
            pico_meta_q <= pico;
            pico_sync_q <= pico_meta_q;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;

            // A load sees the holding register as it was before any
            // same-cycle write, so a colliding write survives for later.
            if (do_load) begin
                if (hold_full_q) begin
                    tx_shift_q  <= hold_q;
                    hold_full_q <= 1'b0;
                end else begin
                    tx_shift_q <= DEFAULT_TX_WORD;
                    underrun_q <= 1'b1;
                end
            end
            if (hold_wr) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end

            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!cs_sync_q) begin
                        state_q   <= ACTIVE;
                        bit_cnt_q <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_sync_q) begin
                        // Partial word is dropped silently.
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_shift_q <= rx_word;
                            if (last_bit) begin
                                bit_cnt_q <= '0;
                                if (!rx_valid_q || rx_ready) begin
                                    rx_data_q  <= rx_word;
                                    rx_valid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CW'(1);
                            end
                        end
                        if (shift_edge && (bit_cnt_q != '0)) begin
                            tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign poci     = (state_q == ACTIVE) && tx_shift_q[DATA_WIDTH-1];
    assign tx_ready = !hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_rvx_spi_peripheral.sv
// Testbench for rvx_spi_peripheral: mode 0 and mode 3 instances,
// scoreboarded rx stream and model-predicted poci words.
module tb_rvx_spi_peripheral;

    localparam int DW = 8;
    localparam int PH = 8;

    typedef logic [DW-1:0] q8_t[$];

    logic          clock = 1'b0;
    logic          reset    [2];
    logic          sclk     [2];
    logic          pico     [2];
    logic          cs       [2];
    logic          poci     [2];
    logic [DW-1:0] tx_data  [2];
    logic          tx_valid [2];
    logic          tx_ready [2];
    logic [DW-1:0] rx_data  [2];
    logic          rx_valid [2];
    logic          rx_ready [2];
    logic          overrun  [2];
    logic          underrun [2];

    int checks   = 0;
    int failures = 0;

    q8_t host_q   [2];
    q8_t model_tx [2];
    q8_t exp_rx   [2];
    int  exp_und  [2];
    int  got_und  [2];
    int  exp_ovr  [2];
    int  got_ovr  [2];
    bit  rx_held  [2];

    always #5 clock = ~clock;

    rvx_spi_peripheral #(
        .CPOL(1'b0), .CPHA(1'b0), .DATA_WIDTH(DW)
    ) dut0 (
        .clock(clock), .reset(reset[0]), .sclk(sclk[0]),
        .pico(pico[0]), .cs(cs[0]), .poci(poci[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
        .overrun(overrun[0]), .underrun(underrun[0])
    );

    rvx_spi_peripheral #(
        .CPOL(1'b1), .CPHA(1'b1), .DATA_WIDTH(DW)
    ) dut3 (
        .clock(clock), .reset(reset[1]), .sclk(sclk[1]),
        .pico(pico[1]), .cs(cs[1]), .poci(poci[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
        .overrun(overrun[1]), .underrun(underrun[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each load takes the oldest host word, else default.
    function automatic logic [DW-1:0] model_load(input int m);
        if (model_tx[m].size() > 0) return model_tx[m].pop_front();
        exp_und[m]++;
        return '0;
    endfunction

    // Reference model: completed word is kept unless an older one is
    // still waiting and not being accepted.
    function automatic void model_rx(input int m, input logic [DW-1:0] w);
        if (rx_ready[m]) begin
            exp_rx[m].push_back(w);
        end else if (rx_held[m]) begin
            exp_ovr[m]++;
        end else begin
            exp_rx[m].push_back(w);
            rx_held[m] = 1'b1;
        end
    endfunction

    function automatic void queue_tx(input int m, input logic [DW-1:0] w);
        host_q[m].push_back(w);
        model_tx[m].push_back(w);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Host tx feeder: offers queued words one at a time.
    initial begin
        for (int m = 0; m < 2; m++) begin
            tx_valid[m] = 1'b0;
            tx_data[m]  = '0;
        end
        forever begin
            bit ok [2];
            @(negedge clock);
            for (int m = 0; m < 2; m++) ok[m] = tx_valid[m] && tx_ready[m];
            @(posedge clock);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (ok[m]) begin
                    void'(host_q[m].pop_front());
                    tx_valid[m] = 1'b0;
                end
                if (!tx_valid[m] && host_q[m].size() > 0) begin
                    tx_data[m]  = host_q[m][0];
                    tx_valid[m] = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a word is handed over.
    initial begin
        for (int m = 0; m < 2; m++) begin
            got_und[m] = 0;
            got_ovr[m] = 0;
        end
        forever begin
            @(negedge clock);
            for (int m = 0; m < 2; m++) begin
                if (underrun[m] === 1'b1) got_und[m]++;
                if (overrun[m] === 1'b1) got_ovr[m]++;
                if (rx_valid[m] === 1'b1 && rx_ready[m] === 1'b1) begin
                    if (exp_rx[m].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rx_unexpected: got %0h expected none",
                                 rx_data[m]);
                    end else begin
                        chk("rx_data", 32'(rx_data[m]),
                            32'(exp_rx[m].pop_front()));
                    end
                end
            end
        end
    end

    task automatic lat_check(input int m);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("rx_valid_lat2", 32'(rx_valid[m]), 32'd0);
        @(posedge clock);
        #1;
        chk("rx_valid_lat3", 32'(rx_valid[m]), 32'd1);
        #1;
        tick(PH - 3);
    endtask

    task automatic xfer_bits(input int m, input logic [DW-1:0] w,
                             input int nbits, input bit lat,
                             output logic [DW-1:0] got);
        logic cp;
        cp  = (m == 1);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            if (m == 1) sclk[m] = ~cp;
            pico[m] = w[DW-1-i];
            tick(PH);
            got[DW-1-i] = poci[m];
            sclk[m] = (m == 0) ? ~cp : cp;
            if (nbits == DW && i == DW - 1) model_rx(m, w);
            if (lat && i == nbits - 1) lat_check(m);
            else tick(PH);
            if (m == 0) sclk[m] = cp;
        end
    endtask

    task automatic wait_hold(input int m);
        for (int i = 0; i < 50 && tx_ready[m] !== 1'b0; i++) tick(1);
        chk("tx_hold_filled", 32'(tx_ready[m]), 32'd0);
    endtask

    // One cs-low session of nw words; last one cut to pbits if nonzero.
    task automatic session(input int m, input logic [DW-1:0] words [4],
                           input int nw, input int pbits, input bit lat);
        logic [DW-1:0] e;
        logic [DW-1:0] got;
        int            nb;
        e = '0;
        if (model_tx[m].size() > 0) wait_hold(m);
        cs[m] = 1'b0;
        if (m == 0) e = model_load(m);
        tick(PH);
        if (lat) chk("tx_ready_after_cs", 32'(tx_ready[m]), 32'd1);
        for (int k = 0; k < nw; k++) begin
            if (m == 1) e = model_load(m);
            nb = (pbits != 0 && k == nw - 1) ? pbits : DW;
            xfer_bits(m, words[k], nb, lat && k == 0, got);
            if (nb == DW) begin
                chk("poci_word", 32'(got), 32'(e));
                if (m == 0) e = model_load(m);
            end
        end
        tick(PH);
        cs[m] = 1'b1;
        tick(PH);
    endtask

    task automatic check_counts(input int m);
        chk("underrun_count", 32'(got_und[m]), 32'(exp_und[m]));
        chk("overrun_count", 32'(got_ovr[m]), 32'(exp_ovr[m]));
        chk("rx_pending", 32'(exp_rx[m].size()), 32'd0);
    endtask

    task automatic check_reset(input int m);
        chk("rst_poci", 32'(poci[m]), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready[m]), 32'd1);
        chk("rst_rx_valid", 32'(rx_valid[m]), 32'd0);
        chk("rst_rx_data", 32'(rx_data[m]), 32'd0);
        chk("rst_overrun", 32'(overrun[m]), 32'd0);
        chk("rst_underrun", 32'(underrun[m]), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w [4];
        logic [DW-1:0] got;
        int            nw;
        int            m;
        int            nq;
        for (int i = 0; i < 2; i++) begin
            reset[i]    = 1'b1;
            cs[i]       = 1'b1;
            sclk[i]     = (i == 1);
            pico[i]     = 1'b0;
            rx_ready[i] = 1'b1;
            exp_und[i]  = 0;
            exp_ovr[i]  = 0;
            rx_held[i]  = 1'b0;
        end
        for (int i = 0; i < 4; i++) w[i] = '0;
        tick(3);
        for (int i = 0; i < 2; i++) check_reset(i);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        tick(4);

        // Mode 0 basic with latency check.
        queue_tx(0, 8'h3C);
        w[0] = 8'hA5;
        session(0, w, 1, 0, 1'b1);
        chk("rx_data_a5", 32'(rx_data[0]), 32'h0A5);
        check_counts(0);

        // Mode 3 back-to-back with queued tx words.
        queue_tx(1, 8'hF0);
        queue_tx(1, 8'h0F);
        w[0] = 8'h01;
        w[1] = 8'h80;
        session(1, w, 2, 0, 1'b0);
        check_counts(1);

        // Mode 3 with nothing queued: one underrun per word.
        for (int i = 0; i < 3; i++) w[i] = DW'($urandom);
        session(1, w, 3, 0, 1'b0);
        check_counts(1);

        // Overrun: two words with rx_ready low.
        rx_ready[0] = 1'b0;
        w[0] = 8'h11;
        session(0, w, 1, 0, 1'b0);
        w[0] = DW'($urandom);
        session(0, w, 1, 0, 1'b0);
        chk("rx_data_kept", 32'(rx_data[0]), 32'h011);
        chk("rx_valid_kept", 32'(rx_valid[0]), 32'd1);
        rx_ready[0] = 1'b1;
        tick(1);
        rx_ready[0] = 1'b0;
        rx_held[0]  = 1'b0;
        w[0] = 8'h22;
        session(0, w, 1, 0, 1'b0);
        chk("rx_data_22", 32'(rx_data[0]), 32'h022);
        rx_ready[0] = 1'b1;
        rx_held[0]  = 1'b0;
        tick(2);
        check_counts(0);

        // cs abort after 5 bits, then full word.
        for (int i = 0; i < 2; i++) begin
            w[0] = 8'hFF;
            session(i, w, 1, 5, 1'b0);
            chk("abort_no_valid", 32'(rx_valid[i]), 32'd0);
            w[0] = 8'h5A;
            session(i, w, 1, 0, 1'b0);
            check_counts(i);
        end

        // Reset mid-word on the mode 0 instance.
        queue_tx(0, 8'h96);
        wait_hold(0);
        cs[0] = 1'b0;
        void'(model_load(0));
        tick(PH);
        xfer_bits(0, 8'hFF, 3, 1'b0, got);
        reset[0] = 1'b1;
        #1;
        check_reset(0);
        model_tx[0].delete();
        rx_held[0] = 1'b0;
        cs[0]   = 1'b1;
        sclk[0] = 1'b0;
        pico[0] = 1'b0;
        tick(3);
        reset[0] = 1'b0;
        tick(PH);
        w[0] = 8'hC3;
        session(0, w, 1, 0, 1'b0);
        chk("rx_data_c3", 32'(rx_data[0]), 32'h0C3);
        check_counts(0);

        // Randomized sessions on both instances.
        for (int it = 0; it < 10; it++) begin
            m  = int'($urandom_range(0, 1));
            nw = int'($urandom_range(1, 3));
            for (int i = 0; i < nw; i++) w[i] = DW'($urandom);
            nq = int'($urandom_range(0, nw + ((m == 0) ? 1 : 0)));
            for (int i = 0; i < nq; i++) queue_tx(m, DW'($urandom));
            session(m, w, nw, 0, 1'b0);
        end
        tick(4);
        for (int i = 0; i < 2; i++) check_counts(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rvx_spi_peripheral.md
Name: rvx_spi_peripheral

Overview:
- SPI responder (target) that sits on the far end of the RVX SPI controller's sclk/pico/poci/cs interface.
- Used as a board-level or testbench peer: presents a host-side byte stream to the controller and returns the bytes the controller shifts out.
- Pins are asynchronous to `clock` and are oversampled through synchronizers; the host side uses valid/ready handshakes.

Parameters:
- CPOL, 0, idle level of sclk.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- DATA_WIDTH, 8, bits per word (2..32), MSB first.
- DEFAULT_TX_WORD, 8'h00 zero-extended to DATA_WIDTH, word shifted out when no tx word is pending.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from controller.
- pico  input  1  controller-out data.
- cs  input  1  chip select, active low.
- poci  output  1  peripheral-out data.
- tx_data  input  DATA_WIDTH  word to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  tx holding register empty.
- rx_data  output  DATA_WIDTH  last received word.
- rx_valid  output  1  rx_data valid; held until accepted.
- rx_ready  input  1  host accepts rx_data.
- overrun  output  1  one-cycle pulse: word received while rx_valid was high and not accepted.
- underrun  output  1  one-cycle pulse: DEFAULT_TX_WORD loaded because the holding register was empty.

Behaviour:
- Reset (async, active-high) sets all of the following; reset mid-transfer aborts it immediately.
  - Synchronizers: sclk = CPOL, cs = 1, pico = 0.
  - Outputs: poci = 0, tx_ready = 1, rx_valid = 0, rx_data = 0, overrun = 0, underrun = 0.
  - Internal state: bit_count = 0, state IDLE.
- Synchronization:
  - sclk, cs and pico each pass through 2 flops.
  - Edges are detected against the previous synchronized sclk.
  - Leading edge = transition away from CPOL. Trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA = 0, else trailing. Shift edge = the other.
- Timing constraint: each sclk phase must be ≥ 4 clock periods; faster sclk is unsupported.
- State IDLE (synchronized cs = 1):
  - poci = 0; edges are ignored.
  - Synchronized cs falling moves to ACTIVE and clears bit_count.
  - If CPHA = 0, a word load happens in the same cycle.
- State ACTIVE:
  - poci = MSB of the tx shift register.
  - Sample edge: rx_shift <= {rx_shift[DATA_WIDTH-2:0], pico_sync}; bit_count += 1.
  - When bit_count reaches DATA_WIDTH on a sample edge, the word completes: bit_count returns to 0.
    - If rx_valid is 0, or rx_ready is 1 that cycle: rx_data <= completed word, rx_valid = 1 next cycle.
    - Otherwise the new word is dropped, rx_data is kept, and overrun pulses.
  - Shift edge:
    - CPHA = 1 and bit_count = 0: word load.
    - CPHA = 0 and bit_count = 0: word load (this is the shift edge after a completed word).
    - Any other case: tx_shift shifts left by 1.
  - Synchronized cs rising returns to IDLE.
    - A partial word is discarded, with no rx_valid and no overrun.
    - A tx word already loaded counts as consumed.
- Word load:
  - If the holding register is full, tx_shift <= holding register and the register becomes empty (tx_ready rises next cycle).
  - Otherwise tx_shift <= DEFAULT_TX_WORD and underrun pulses.
- TX handshake:
  - Holding register is written when tx_valid & tx_ready; tx_ready falls the next cycle.
  - A write and a load in the same cycle: the load uses the pre-write state, so it loads DEFAULT_TX_WORD with underrun. The written word stays held for the next load.
- RX handshake:
  - rx_valid & rx_ready clears rx_valid next cycle.
  - Accept and word completion in the same cycle: the new word is stored, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 3 clocks after the final sample sclk edge at the pin (2 sync + 1 register).

Test Plan:
- Mode 0, DATA_WIDTH = 8, holding register = 8'h3C written before cs falls; controller sends 8'hA5 with sclk = clock/16 → poci bits 0,0,1,1,1,1,0,0 (MSB first); rx_data = 8'hA5 and rx_valid = 1 three clocks after the 8th rising sclk; tx_ready = 1 after cs falls.
- Mode 3 (CPOL = 1, CPHA = 1): two back-to-back words 8'h01, 8'h80 with tx words 8'hF0, 8'h0F queued in turn → poci returns F0 then 0F; rx_data sequence 01 then 80, each taken with rx_ready.
- No tx word queued, DEFAULT_TX_WORD = 8'h00 → poci stays 0 for 8 bits; underrun pulses exactly once per word.
- Two words received with rx_ready held 0 → first word 8'h11 retained, overrun pulses once at second completion; then rx_ready for one cycle and word 8'h22 → rx_data = 8'h22, no overrun.
- cs raised after 5 bits of 8'hFF, then a full transfer of 8'h5A → no rx_valid for the partial word; next rx_data = 8'h5A (bit_count was reset).
- reset asserted mid-word (bit 3) → outputs at reset values in the same cycle; the next full transfer of 8'hC3 is received correctly.
